// File: rtl/dmem_unit_if.sv
// Request/response bus between a load/store issuer and the data-memory unit.
// The slave side (dmem_unit) also exports its saturating fault counter.
interface dmem_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [7:0]  fault_cnt;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, fault_cnt
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, fault_cnt
    );
endinterface

// File: rtl/dmem_unit.sv
// Single-outstanding RISC-V data memory: byte-lane stores, extended loads,
// misalignment/illegal-op faults, fixed programmable response latency.
module dmem_unit #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input logic       clk,
    input logic       rst,
    dmem_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    state_t            stateNext;
    logic [3:0]        cnt;
    logic              weReg;
    logic [1:0]        offReg;
    logic [ADDR_W-1:0] idxReg;
    logic [2:0]        f3Reg;
    logic [31:0]       wdataReg;
    logic              faultReg;
    logic [7:0]        faultCnt;
    logic [31:0]       rdWord;
    logic [31:0]       shifted;
    logic [31:0]       extData;
    logic              reqFault;
    logic              accept;
    logic              finish;
    logic [3:0]        byteEn;
    logic [7:0]        laneData [4];
    logic              unusedAddr;

    logic [31:0] mem [2**ADDR_W];

    // Upper address bits alias onto the same words.
    assign unusedAddr = ^bus.req_addr[31:ADDR_W+2];

    always_comb begin
        reqFault = 1'b0;
        case (bus.req_funct3)
            3'b000:  reqFault = 1'b0;
            3'b001:  reqFault = bus.req_addr[0];
            3'b010:  reqFault = (bus.req_addr[1:0] != 2'b00);
            3'b100:  reqFault = bus.req_we;
            3'b101:  reqFault = bus.req_we | bus.req_addr[0];
            default: reqFault = 1'b1;
        endcase
    end

    always_comb begin
        stateNext     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        accept        = 1'b0;
        finish        = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    finish    = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            faultCnt <= 8'd0;
        end else begin
            state <= stateNext;
            if (accept) begin
                weReg    <= bus.req_we;
                offReg   <= bus.req_addr[1:0];
                idxReg   <= bus.req_addr[ADDR_W+1:2];
                f3Reg    <= bus.req_funct3;
                wdataReg <= bus.req_wdata;
                faultReg <= reqFault;
                cnt      <= 4'(LATENCY - 1);
                if (reqFault && faultCnt != 8'hFF) faultCnt <= faultCnt + 8'd1;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Per-lane enable and data: SB replicates the low byte, SH the low half.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign byteEn[gi]   = f3Reg[1] ? 1'b1 :
                                  f3Reg[0] ? (offReg[1] == LANE[1]) :
                                             (offReg == LANE);
            assign laneData[gi] = f3Reg[1] ? wdataReg[8*gi +: 8] :
                                  f3Reg[0] ? wdataReg[8*(gi%2) +: 8] :
                                             wdataReg[7:0];
        end
    endgenerate

    // Reset blocks the WAIT->RESP write so a pending store is discarded.
    always_ff @(posedge clk) begin
        if (finish && !rst) begin
            rdWord <= mem[idxReg];
            if (weReg && !faultReg) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteEn[i]) mem[idxReg][8*i +: 8] <= laneData[i];
                end
            end
        end
    end

    assign shifted = rdWord >> {offReg, 3'b000};

    always_comb begin
        extData = 32'd0;
        case (f3Reg)
            3'b000:  extData = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extData = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  extData = shifted;
            3'b100:  extData = {24'd0, shifted[7:0]};
            3'b101:  extData = {16'd0, shifted[15:0]};
            default: extData = 32'd0;
        endcase
    end

    // Outputs derive only from latched state, so they hold for all of RESP.
    assign bus.rsp_rdata = (state == RESP && !weReg && !faultReg) ? extData : 32'd0;
    assign bus.rsp_fault = (state == RESP) && faultReg;
    assign bus.fault_cnt = faultCnt;
endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench: one LATENCY=1 and one LATENCY=4 instance of dmem_unit,
// checked with immediate assertions against hand-computed values.
module tb_dmem_unit;
    logic clk = 1'b0;
    logic rst1;
    logic rst4;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    dmem_unit_if b1 ();
    dmem_unit_if b4 ();

    dmem_unit #(.ADDR_W(12), .LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1.slave));
    dmem_unit #(.ADDR_W(12), .LATENCY(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(virtual dmem_unit_if v);
        v.req_valid  = 1'b0;
        v.req_we     = 1'b0;
        v.req_addr   = 32'd0;
        v.req_funct3 = 3'd0;
        v.req_wdata  = 32'd0;
        v.rsp_ready  = 1'b0;
    endtask

    // One full request/response handshake with latency, data and fault checks.
    task automatic txn(virtual dmem_unit_if v, input int expLat, input string tag,
                       input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] expData, input logic expFault);
        int lat;
        @(negedge clk);
        check({tag, ".ready"}, 32'(v.req_ready), 32'd1);
        v.req_valid  = 1'b1;
        v.req_we     = we;
        v.req_addr   = addr;
        v.req_funct3 = f3;
        v.req_wdata  = wd;
        @(posedge clk);
        #1 v.req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!v.rsp_valid && lat < 32);
        check({tag, ".lat"}, 32'(lat), 32'(expLat));
        check({tag, ".rdata"}, v.rsp_rdata, expData);
        check({tag, ".fault"}, 32'(v.rsp_fault), 32'(expFault));
        $display("txn %s we=%0d addr=%h f3=%0d rdata=%h fault=%0d lat=%0d",
                 tag, we, addr, f3, v.rsp_rdata, v.rsp_fault, lat);
        v.rsp_ready = 1'b1;
        @(posedge clk);
        #1 v.rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        rst1 = 1'b1;
        rst4 = 1'b1;
        idle(b1);
        idle(b4);
        // Requests presented during reset must not be taken.
        b1.req_valid  = 1'b1;
        b1.req_we     = 1'b1;
        b1.req_addr   = 32'h10;
        b1.req_funct3 = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.valid1", 32'(b1.rsp_valid), 32'd0);
        check("rst.rdata1", b1.rsp_rdata, 32'd0);
        check("rst.fault1", 32'(b1.rsp_fault), 32'd0);
        check("rst.cnt1", 32'(b1.fault_cnt), 32'd0);
        check("rst.valid4", 32'(b4.rsp_valid), 32'd0);
        rst1 = 1'b0;
        rst4 = 1'b0;
        b1.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst.ready1", 32'(b1.req_ready), 32'd1);
        check("post_rst.cnt1", 32'(b1.fault_cnt), 32'd0);

        // Basic store/load and byte-lane behaviour
        txn(b1, 1, "sw_dead", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'd0, 1'b0);
        txn(b1, 1, "lw_dead", 1'b0, 32'h10, 3'b010, 32'd0, 32'hDEADBEEF, 1'b0);
        txn(b1, 1, "sb_80", 1'b1, 32'h13, 3'b000, 32'h00000080, 32'd0, 1'b0);
        txn(b1, 1, "lb_13", 1'b0, 32'h13, 3'b000, 32'd0, 32'hFFFFFF80, 1'b0);
        txn(b1, 1, "lbu_13", 1'b0, 32'h13, 3'b100, 32'd0, 32'h00000080, 1'b0);
        txn(b1, 1, "lw_sb", 1'b0, 32'h10, 3'b010, 32'd0, 32'h80ADBEEF, 1'b0);
        txn(b1, 1, "sh_1234", 1'b1, 32'h10, 3'b001, 32'hFFFF1234, 32'd0, 1'b0);
        txn(b1, 1, "lw_sh", 1'b0, 32'h10, 3'b010, 32'd0, 32'h80AD1234, 1'b0);
        txn(b1, 1, "lh_12", 1'b0, 32'h12, 3'b001, 32'd0, 32'hFFFF80AD, 1'b0);
        txn(b1, 1, "lhu_12", 1'b0, 32'h12, 3'b101, 32'd0, 32'h000080AD, 1'b0);
        txn(b1, 1, "lb_10", 1'b0, 32'h10, 3'b000, 32'd0, 32'h00000034, 1'b0);

        // Faults: no write, zero data, counted
        txn(b1, 1, "lh_mis", 1'b0, 32'h11, 3'b001, 32'd0, 32'd0, 1'b1);
        txn(b1, 1, "sw_mis", 1'b1, 32'h12, 3'b010, 32'h0, 32'd0, 1'b1);
        txn(b1, 1, "f3_011", 1'b0, 32'h10, 3'b011, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        check("fault_cnt3", 32'(b1.fault_cnt), 32'd3);
        txn(b1, 1, "sbu_st", 1'b1, 32'h10, 3'b100, 32'h000000FF, 32'd0, 1'b1);
        txn(b1, 1, "lw_after_f", 1'b0, 32'h10, 3'b010, 32'd0, 32'h80AD1234, 1'b0);
        @(negedge clk);
        check("fault_cnt4", 32'(b1.fault_cnt), 32'd4);

        // Upper address bits alias
        txn(b1, 1, "sw_alias", 1'b1, 32'h4010, 3'b010, 32'hA5A5A5A5, 32'd0, 1'b0);
        txn(b1, 1, "lw_alias", 1'b0, 32'h0010, 3'b010, 32'd0, 32'hA5A5A5A5, 1'b0);

        // Saturation of the fault counter
        for (int i = 0; i < 251; i++)
            txn(b1, 1, "sat", 1'b0, 32'h10, 3'b111, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        check("fault_cnt255", 32'(b1.fault_cnt), 32'd255);
        txn(b1, 1, "sat_extra", 1'b0, 32'h10, 3'b110, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        check("fault_cnt_sat", 32'(b1.fault_cnt), 32'd255);

        // LATENCY=4 instance
        txn(b4, 4, "sw4", 1'b1, 32'h20, 3'b010, 32'h11223344, 32'd0, 1'b0);
        txn(b4, 4, "lh_mis4", 1'b0, 32'h21, 3'b001, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        check("fault_cnt4_1", 32'(b4.fault_cnt), 32'd1);

        // Response held under backpressure; new requests ignored meanwhile
        @(negedge clk);
        b4.req_valid  = 1'b1;
        b4.req_we     = 1'b0;
        b4.req_addr   = 32'h20;
        b4.req_funct3 = 3'b010;
        @(posedge clk);
        #1 b4.req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!b4.rsp_valid && lat < 32);
        check("hold.lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("hold.valid", 32'(b4.rsp_valid), 32'd1);
            check("hold.rdata", b4.rsp_rdata, 32'h11223344);
            check("hold.ready", 32'(b4.req_ready), 32'd0);
            $display("txn hold cycle %0d rdata=%h", i, b4.rsp_rdata);
            b4.req_valid  = 1'b1;
            b4.req_we     = 1'b1;
            b4.req_funct3 = 3'b010;
            b4.req_wdata  = 32'hCAFEBABE;
            @(posedge clk);
            @(negedge clk);
        end
        b4.req_valid = 1'b0;
        b4.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b4.rsp_ready = 1'b0;
        txn(b4, 4, "lw_hold", 1'b0, 32'h20, 3'b010, 32'd0, 32'h11223344, 1'b0);

        // Reset on the edge that would have written a pending store
        @(negedge clk);
        b4.req_valid  = 1'b1;
        b4.req_we     = 1'b1;
        b4.req_addr   = 32'h20;
        b4.req_funct3 = 3'b010;
        b4.req_wdata  = 32'hFFFFFFFF;
        @(posedge clk);
        #1 b4.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_wait.valid", 32'(b4.rsp_valid), 32'd0);
        check("rst_wait.cnt", 32'(b4.fault_cnt), 32'd0);
        $display("txn reset during pending store");
        rst4 = 1'b0;
        txn(b4, 4, "lw_after_rst", 1'b0, 32'h20, 3'b010, 32'd0, 32'h11223344, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
